// File: rtl/sidewalk_phase_ctrl.sv
// sidewalk_phase_ctrl
// Pedestrian crossing phase sequencer:
//   GREEN -> YELLOW -> RED_IN -> WALK -> HURRY -> RED_OUT -> GREEN
// Drives the vehicle lights, the walk/hurry display selects, a walking-figure
// frame tick and a seconds-remaining readout. GREEN is held until a
// pedestrian request is latched and the minimum green time has elapsed.
//
// Optional feature: define PED_DEBOUNCE_EN to add a DEB_CYCLES stability
// filter after the button synchronizer. Without it, the synchronizer output
// feeds the edge detector directly and no debounce counter exists.
module sidewalk_phase_ctrl #(
  parameter int unsigned SEC_DIV       = 50000000,
  parameter int unsigned FRAME_DIV     = 1562500,
  parameter int unsigned MIN_GREEN_SEC = 10,
  parameter int unsigned YELLOW_SEC    = 3,
  parameter int unsigned CLEAR_SEC     = 1,
  parameter int unsigned WALK_SEC      = 12,
  parameter int unsigned HURRY_SEC     = 5,
  parameter int unsigned DEB_CYCLES    = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       car_g,
  output logic       car_y,
  output logic       car_r,
  output logic       walk,
  output logic       hurry,
  output logic       frame_tick,
  output logic [5:0] remain,
  output logic       req_pending
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: every duration must fit the 6-bit remain readout and
  // be non-zero, and every divider must be at least one clock.
  // ---------------------------------------------------------------------------
  localparam bit CFG_OK =
      (MIN_GREEN_SEC >= 32'd1) && (MIN_GREEN_SEC <= 32'd63) &&
      (YELLOW_SEC    >= 32'd1) && (YELLOW_SEC    <= 32'd63) &&
      (CLEAR_SEC     >= 32'd1) && (CLEAR_SEC     <= 32'd63) &&
      (WALK_SEC      >= 32'd1) && (WALK_SEC      <= 32'd63) &&
      (HURRY_SEC     >= 32'd1) && (HURRY_SEC     <= 32'd63) &&
      (SEC_DIV       >= 32'd1) && (FRAME_DIV     >= 32'd1) &&
      (DEB_CYCLES    >= 32'd1);

  if (!CFG_OK) begin : g_cfg_check
    $error("sidewalk_phase_ctrl: parameter out of range");
  end

  // Counter widths; a divider of 1 still needs a 1-bit counter.
  localparam int SEC_W = (SEC_DIV   > 32'd1) ? $clog2(SEC_DIV)   : 1;
  localparam int FRM_W = (FRAME_DIV > 32'd1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_DIV - 32'd1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_DIV - 32'd1);

  // ---------------------------------------------------------------------------
  // Phase encoding
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_GREEN   = 3'd0,
    ST_YELLOW  = 3'd1,
    ST_RED_IN  = 3'd2,
    ST_WALK    = 3'd3,
    ST_HURRY   = 3'd4,
    ST_RED_OUT = 3'd5
  } state_t;

  // Duration in seconds loaded into remain when a phase is entered.
  function automatic logic [5:0] dur_of(input state_t s);
    case (s)
      ST_GREEN:   dur_of = 6'(MIN_GREEN_SEC);
      ST_YELLOW:  dur_of = 6'(YELLOW_SEC);
      ST_RED_IN:  dur_of = 6'(CLEAR_SEC);
      ST_WALK:    dur_of = 6'(WALK_SEC);
      ST_HURRY:   dur_of = 6'(HURRY_SEC);
      ST_RED_OUT: dur_of = 6'(CLEAR_SEC);
      default:    dur_of = 6'(MIN_GREEN_SEC);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  state_t           state_r;
  state_t           state_nxt_s;
  logic [SEC_W-1:0] sec_cnt_r;
  logic [SEC_W-1:0] sec_cnt_nxt_s;
  logic [FRM_W-1:0] frame_cnt_r;
  logic [FRM_W-1:0] frame_cnt_nxt_s;
  logic [5:0]       remain_nxt_s;
  logic             req_nxt_s;
  logic             sec_tick_s;
  logic             timed_done_s;
  logic             enter_s;
  logic             enter_walk_s;
  logic             walk_nxt_s;

  logic             sync1_r;
  logic             sync2_r;
  logic             btn_lvl_s;
  logic             btn_prev_r;
  logic             btn_rise_s;

  // ---------------------------------------------------------------------------
  // Button conditioning: two-flop synchronizer, optional debounce, edge detect
  // ---------------------------------------------------------------------------

  // Bring the asynchronous button into the clock domain and keep the
  // previous conditioned level for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      btn_prev_r <= 1'b0;
    end else begin
      sync1_r    <= btn;
      sync2_r    <= sync1_r;
      btn_prev_r <= btn_lvl_s;
    end
  end

`ifdef PED_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 32'd1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);

  logic [DEB_W-1:0] deb_cnt_r;
  logic             deb_lvl_r;

  // Accept a new synchronized level only after it has held steady for
  // DEB_CYCLES consecutive clocks; any glitch back restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_r <= '0;
      deb_lvl_r <= 1'b0;
    end else if (sync2_r == deb_lvl_r) begin
      deb_cnt_r <= '0;
    end else if (deb_cnt_r == DEB_LAST) begin
      deb_cnt_r <= '0;
      deb_lvl_r <= sync2_r;
    end else begin
      deb_cnt_r <= deb_cnt_r + 1'b1;
    end
  end

  assign btn_lvl_s = deb_lvl_r;
`else
  assign btn_lvl_s = sync2_r;
`endif

  // A held button yields a single rise, so it can only request once.
  assign btn_rise_s = btn_lvl_s & ~btn_prev_r;

  // ---------------------------------------------------------------------------
  // Phase timing
  // ---------------------------------------------------------------------------
  assign sec_tick_s   = (sec_cnt_r == SEC_LAST);
  assign timed_done_s = sec_tick_s && (remain == 6'd1);

  // Next-phase selection: timed phases leave on their last second tick,
  // GREEN additionally waits for a latched pedestrian request.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_GREEN: begin
        if (req_pending && ((remain == 6'd0) || timed_done_s)) begin
          state_nxt_s = ST_YELLOW;
        end else begin
          state_nxt_s = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        if (timed_done_s) state_nxt_s = ST_RED_IN;
        else              state_nxt_s = ST_YELLOW;
      end
      ST_RED_IN: begin
        if (timed_done_s) state_nxt_s = ST_WALK;
        else              state_nxt_s = ST_RED_IN;
      end
      ST_WALK: begin
        if (timed_done_s) state_nxt_s = ST_HURRY;
        else              state_nxt_s = ST_WALK;
      end
      ST_HURRY: begin
        if (timed_done_s) state_nxt_s = ST_RED_OUT;
        else              state_nxt_s = ST_HURRY;
      end
      ST_RED_OUT: begin
        if (timed_done_s) state_nxt_s = ST_GREEN;
        else              state_nxt_s = ST_RED_OUT;
      end
      default: state_nxt_s = ST_GREEN;
    endcase
  end

  // Counter, remain and request updates; every phase entry restarts the
  // second counter and reloads remain with the new phase's duration.
  always_comb begin
    enter_s         = (state_nxt_s != state_r);
    enter_walk_s    = enter_s && (state_nxt_s == ST_WALK);
    walk_nxt_s      = (state_nxt_s == ST_WALK) || (state_nxt_s == ST_HURRY);
    sec_cnt_nxt_s   = sec_cnt_r;
    remain_nxt_s    = remain;
    frame_cnt_nxt_s = frame_cnt_r;
    req_nxt_s       = req_pending;

    if (enter_s) begin
      sec_cnt_nxt_s = '0;
      remain_nxt_s  = dur_of(state_nxt_s);
    end else begin
      if (sec_tick_s) sec_cnt_nxt_s = '0;
      else            sec_cnt_nxt_s = sec_cnt_r + 1'b1;
      if (sec_tick_s && (remain != 6'd0)) remain_nxt_s = remain - 6'd1;
      else                                 remain_nxt_s = remain;
    end

    // Frame counter free-runs, realigned to the start of each walk phase.
    if (enter_walk_s) begin
      frame_cnt_nxt_s = '0;
    end else if (frame_cnt_r == FRM_LAST) begin
      frame_cnt_nxt_s = '0;
    end else begin
      frame_cnt_nxt_s = frame_cnt_r + 1'b1;
    end

    // Clearing on WALK entry takes priority over a coincident new press.
    if (enter_walk_s) begin
      req_nxt_s = 1'b0;
    end else if (btn_rise_s && (state_r != ST_WALK) && (state_r != ST_HURRY)) begin
      req_nxt_s = 1'b1;
    end else begin
      req_nxt_s = req_pending;
    end
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they change on the same edge as the phase itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_GREEN;
      sec_cnt_r   <= '0;
      frame_cnt_r <= '0;
      remain      <= 6'(MIN_GREEN_SEC);
      req_pending <= 1'b0;
      car_g       <= 1'b1;
      car_y       <= 1'b0;
      car_r       <= 1'b0;
      walk        <= 1'b0;
      hurry       <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sec_cnt_r   <= sec_cnt_nxt_s;
      frame_cnt_r <= frame_cnt_nxt_s;
      remain      <= remain_nxt_s;
      req_pending <= req_nxt_s;
      car_g       <= (state_nxt_s == ST_GREEN);
      car_y       <= (state_nxt_s == ST_YELLOW);
      car_r       <= (state_nxt_s != ST_GREEN) && (state_nxt_s != ST_YELLOW);
      walk        <= walk_nxt_s;
      hurry       <= (state_nxt_s == ST_HURRY);
      frame_tick  <= walk_nxt_s && (frame_cnt_nxt_s == FRM_LAST);
    end
  end

endmodule

// File: tb/tb_sidewalk_phase_ctrl.sv
// Directed bench for sidewalk_phase_ctrl with small timing parameters:
// SEC_DIV=4, FRAME_DIV=2, MIN_GREEN=3, YELLOW=2, CLEAR=1, WALK=4, HURRY=2.
module tb_sidewalk_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       car_g;
  logic       car_y;
  logic       car_r;
  logic       walk;
  logic       hurry;
  logic       frame_tick;
  logic [5:0] remain;
  logic       req_pending;

  int n_cmp = 0;
  int n_bad = 0;

  // frame_tick observation, updated on every falling edge
  int   walk_run    = 0;
  int   ft_run      = 0;
  int   first_off   = -1;
  int   last_ft_run = -1;
  int   last_first  = -1;
  int   ft_double   = 0;
  int   ft_outside  = 0;
  logic prev_ft     = 1'b0;

  sidewalk_phase_ctrl #(
    .SEC_DIV(4), .FRAME_DIV(2), .MIN_GREEN_SEC(3), .YELLOW_SEC(2),
    .CLEAR_SEC(1), .WALK_SEC(4), .HURRY_SEC(2), .DEB_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .car_g(car_g), .car_y(car_y), .car_r(car_r),
    .walk(walk), .hurry(hurry), .frame_tick(frame_tick),
    .remain(remain), .req_pending(req_pending)
  );

  always #5 clk = ~clk;

  // Track frame ticks inside each walk window (WALK+HURRY) and outside it.
  always @(negedge clk) begin
    if (walk === 1'b1) begin
      if (frame_tick === 1'b1) begin
        if (first_off < 0) first_off = walk_run;
        ft_run = ft_run + 1;
      end
      walk_run = walk_run + 1;
    end else begin
      if (walk_run != 0) begin
        last_ft_run = ft_run;
        last_first  = first_off;
      end
      walk_run  = 0;
      ft_run    = 0;
      first_off = -1;
      if (frame_tick === 1'b1) ft_outside = ft_outside + 1;
    end
    if ((frame_tick === 1'b1) && (prev_ft === 1'b1)) ft_double = ft_double + 1;
    prev_ft = frame_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return car_g;
      1:       return car_y;
      2:       return car_r & ~walk;
      3:       return walk & ~hurry;
      4:       return hurry;
      5:       return walk;
      default: return 1'b0;
    endcase
  endfunction

  // Count consecutive falling edges on which the selected condition holds.
  task automatic run_len(input int sel, output int len);
    len = 0;
    while ((sig(sel) === 1'b1) && (len < 1000)) begin
      len++;
      @(negedge clk);
    end
  endtask

  // Wait (bounded) for the selected condition to reach val.
  task automatic wait_for(input int sel, input logic val, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sig(sel) === val) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit ok;
    int g_cnt;
    int ft_cnt;
    int y_cnt;
    int r_cnt;

    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_car_g", car_g, 1);
    chk("rst_car_y", car_y, 0);
    chk("rst_car_r", car_r, 0);
    chk("rst_walk", walk, 0);
    chk("rst_hurry", hurry, 0);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_remain", remain, 3);
    chk("rst_req", req_pending, 0);
    rst = 1'b0;

`ifdef PED_DEBOUNCE_EN
    // Short 5-clock press must be filtered out.
    btn = 1'b1;
    repeat (5) @(negedge clk);
    btn = 1'b0;
    r_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (req_pending === 1'b1) r_cnt++;
      @(negedge clk);
    end
    chk("deb_short_ignored", r_cnt, 0);
    // 12-clock press: request visible 2+8+1 clocks after the rise.
    btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("deb_req_before", req_pending, 0);
    @(negedge clk);
    chk("deb_req_at_11", req_pending, 1);
    repeat (2) @(negedge clk);
    btn = 1'b0;
    chk("deb_still_green", car_g, 1);
`else
    // --- Full cycle with a one-clock press at cycle 2 ---
    @(negedge clk);
    @(negedge clk);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    run_len(0, len);
    chk("a_green_len", 3 + len, 12);
    chk("a_req_in_yellow", req_pending, 1);
    run_len(1, len);
    chk("a_yellow_len", len, 8);
    run_len(2, len);
    chk("a_red_in_len", len, 4);
    chk("a_walk_car_r", car_r, 1);
    run_len(3, len);
    chk("a_walk_len", len, 16);
    run_len(4, len);
    chk("a_hurry_len", len, 8);
    run_len(2, len);
    chk("a_red_out_len", len, 4);
    chk("a_back_green", car_g, 1);
    chk("a_req_cleared", req_pending, 0);
    chk("a_green_remain", remain, 3);
    chk("frame_count", last_ft_run, 12);
    chk("frame_first_offset", last_first, 1);

    // --- No request for 200 clocks after reset ---
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    g_cnt  = 0;
    ft_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      if (k == 11) chk("b_remain_c11", remain, 1);
      if (k == 12) chk("b_remain_c12", remain, 0);
      if (car_g === 1'b1) g_cnt++;
      if (frame_tick === 1'b1) ft_cnt++;
      @(negedge clk);
    end
    chk("b_green_held", g_cnt, 200);
    chk("b_no_frame_tick", ft_cnt, 0);
    chk("b_remain_sat", remain, 0);

    // --- Button held through WALK gives a single crossing ---
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    wait_for(5, 1'b1, 100, ok);
    chk("c_walk_reached", ok, 1);
    btn = 1'b1;
    wait_for(5, 1'b0, 100, ok);
    chk("c_walk_ended", ok, 1);
    btn = 1'b0;
    wait_for(0, 1'b1, 20, ok);
    chk("c_green_reached", ok, 1);
    chk("c_no_req_after_hold", req_pending, 0);
    y_cnt = 0;
    g_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (car_g === 1'b1) g_cnt++;
      if (car_y === 1'b1) y_cnt++;
      @(negedge clk);
    end
    chk("c_green_stays", g_cnt, 40);
    chk("c_no_yellow", y_cnt, 0);
    btn = 1'b1;
    @(negedge clk);
    btn = 1'b0;
    wait_for(1, 1'b1, 10, ok);
    chk("c_fresh_press_yellow", ok, 1);
    chk("c_fresh_req", req_pending, 1);

    // --- Reset 5 clocks into WALK ---
    wait_for(5, 1'b1, 50, ok);
    chk("d_walk_reached", ok, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("d_car_g", car_g, 1);
    chk("d_walk", walk, 0);
    chk("d_hurry", hurry, 0);
    chk("d_remain", remain, 3);
    chk("d_req", req_pending, 0);
    rst = 1'b0;
    @(negedge clk);

    chk("frame_never_double", ft_double, 0);
    chk("frame_never_outside", ft_outside, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
